kmap_lut_engine: RTL and testbench



---
 rtl/kmap_lut_pkg.sv | 18 +
 rtl/kmap_lut_table.sv | 37 +++
 rtl/kmap_lut_engine.sv | 140 ++++++++++++++
 tb/tb_kmap_lut_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmap_lut_pkg.sv
// kmap_lut_pkg: shared types and constants for the programmable K-map engine.
// Optional hit counter is enabled with the KMAP_LUT_HITCNT_EN macro.
package kmap_lut_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int HITCNT_W = 16;

  // Table depth for an n-input function: one entry per minterm.
  function automatic int depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/kmap_lut_table.sv
// kmap_lut_table: N_CH x DEPTH flop storage. Write port is used during
// table load; read port is purely combinational so the top can register it.
module kmap_lut_table
  import kmap_lut_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [N_IN-1:0] waddr,
  input  logic [N_CH-1:0] wdata,
  input  logic [N_IN-1:0] raddr,
  output logic [N_CH-1:0] rdata
);

  localparam int DEPTH = depth(N_IN);

  // One word per minterm; bit k of a word belongs to channel k.
  logic [N_CH-1:0] mem [DEPTH];

  // Storage: reset clears every entry so dout never carries X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Address width equals N_IN, so every in_vec maps to a real entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/kmap_lut_engine.sv
// kmap_lut_engine: run-time loadable N_IN-input, N_CH-output truth table
// evaluator with a serial config port and a 1-entry registered output stage.
// Define KMAP_LUT_HITCNT_EN to add the saturating hit_count output.
module kmap_lut_engine
  import kmap_lut_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [N_CH-1:0]     cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  input  logic                in_valid,
  input  logic [N_IN-1:0]     in_vec,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_CH-1:0]     dout,
`ifdef KMAP_LUT_HITCNT_EN
  output logic [HITCNT_W-1:0] hit_count,
`endif
  output logic                busy
);

  state_t          state;
  state_t          next_state;
  logic [N_IN-1:0] cnt;
  logic [N_CH-1:0] rdata;
  logic            beat;
  logic            last_beat;
  logic            accept;

  assign beat      = cfg_valid & cfg_ready;
  assign last_beat = beat & (&cnt);
  assign accept    = in_valid & in_ready;

  kmap_lut_table #(
    .N_IN (N_IN),
    .N_CH (N_CH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (beat),
    .waddr (cnt),
    .wdata (cfg_data),
    .raddr (in_vec),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNCFG;
    end else begin
      state <= next_state;
    end
  end

  // Next state: cfg_start always (re)enters LOAD; the last beat enters RUN.
  always_comb begin
    next_state = state;
    case (state)
      UNCFG: if (cfg_start) next_state = LOAD;
      LOAD: begin
        if (cfg_start) next_state = LOAD;
        else if (last_beat) next_state = RUN;
      end
      RUN: if (cfg_start) next_state = LOAD;
      default: next_state = UNCFG;
    endcase
  end

  // Handshake outputs; a cfg_start beat is never taken as data or input.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: cfg_ready = ~cfg_start;
      RUN: begin
        busy     = 1'b0;
        in_ready = ~cfg_start & (~out_valid | out_ready);
      end
      default: ;
    endcase
  end

  // Minterm counter: restarts on cfg_start, wraps to 0 after the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cfg_start) begin
      cnt <= '0;
    end else if (beat) begin
      cnt <= cnt + N_IN'(1);
    end
  end

  // Load-complete pulse lands on the first RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= last_beat;
    end
  end

  // Output register: accept replaces, consume empties, cfg_start discards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (cfg_start || state != RUN) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= rdata;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef KMAP_LUT_HITCNT_EN
  // Saturating count of consumed results whose channel 0 bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
    end else if (cfg_start) begin
      hit_count <= '0;
    end else if (out_valid && out_ready && dout[0] && (hit_count != '1)) begin
      hit_count <= hit_count + HITCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_kmap_lut_engine.sv
// tb_kmap_lut_engine: randomized and directed bench for kmap_lut_engine,
// checked against a truth-table reference model. Honors KMAP_LUT_HITCNT_EN.
module tb_kmap_lut_engine;

  localparam int N_IN  = 4;
  localparam int N_CH  = 2;
  localparam int DEPTH = 16;

  logic            clk;
  logic            reset;
  logic            cfg_start;
  logic            cfg_valid;
  logic [N_CH-1:0] cfg_data;
  logic            cfg_ready;
  logic            cfg_done;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [N_CH-1:0] dout;
  logic            busy;
`ifdef KMAP_LUT_HITCNT_EN
  logic [15:0]     hit_count;
`endif

  kmap_lut_engine #(
    .N_IN (N_IN),
    .N_CH (N_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
`ifdef KMAP_LUT_HITCNT_EN
    .hit_count (hit_count),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one 16-bit truth table per channel, bit m = minterm m.
  logic [15:0] ref_tbl [N_CH];
  int          m_mode;   // 0 unconfigured, 1 loading, 2 running
  int          m_cnt;
  bit          m_ov;
  logic [1:0]  m_dout;
  bit          m_done;
  int          m_hits;

  function automatic logic [1:0] lookup(input int v);
    return {ref_tbl[1][v], ref_tbl[0][v]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    ref_tbl[0] = '0;
    ref_tbl[1] = '0;
    m_mode = 0;
    m_cnt  = 0;
    m_ov   = 0;
    m_dout = '0;
    m_done = 0;
    m_hits = 0;
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, advances the model.
  task automatic applyStimulus(input bit start, input bit cv, input logic [1:0] cd,
                               input bit iv, input logic [3:0] vec, input bit ordy);
    bit exp_cfg_ready, exp_in_ready, beat, acc, n_done;
    cfg_start = start;
    cfg_valid = cv;
    cfg_data  = cd;
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    @(negedge clk);
    exp_cfg_ready = (m_mode == 1) && !start;
    exp_in_ready  = (m_mode == 2) && !start && (!m_ov || ordy);
    checkOutput("cfg_ready", cfg_ready, exp_cfg_ready);
    checkOutput("in_ready", in_ready, exp_in_ready);
    checkOutput("busy", busy, m_mode != 2);
    checkOutput("out_valid", out_valid, m_ov);
    checkOutput("cfg_done", cfg_done, m_done);
    if (m_ov) checkOutput("dout", dout, m_dout);
`ifdef KMAP_LUT_HITCNT_EN
    checkOutput("hit_count", hit_count, m_hits);
`endif
    if (m_ov && ordy && m_dout[0] && m_hits < 65535) m_hits++;
    beat   = cv && exp_cfg_ready;
    acc    = iv && exp_in_ready;
    n_done = beat && (m_cnt == DEPTH - 1);
    if (beat) begin
      ref_tbl[0][m_cnt] = cd[0];
      ref_tbl[1][m_cnt] = cd[1];
    end
    if (start || m_mode != 2) m_ov = 0;
    else if (acc) begin
      m_ov   = 1;
      m_dout = lookup(vec);
    end else if (ordy) m_ov = 0;
    if (start) begin
      m_mode = 1;
      m_cnt  = 0;
      m_hits = 0;
    end else if (beat) begin
      if (m_cnt == DEPTH - 1) begin
        m_mode = 2;
        m_cnt  = 0;
      end else m_cnt++;
    end
    m_done = n_done;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_cfg_ready", cfg_ready, 0);
    checkOutput("rst_cfg_done", cfg_done, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_busy", busy, 1);
`ifdef KMAP_LUT_HITCNT_EN
    checkOutput("rst_hit_count", hit_count, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Full table load; optional random idle cycles between beats.
  task automatic loadTables(input logic [15:0] ch0, input logic [15:0] ch1, input bit gaps);
    applyStimulus(1, 0, '0, 0, '0, 1);
    for (int m = 0; m < DEPTH; m++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          applyStimulus(0, 0, 2'($urandom), 0, '0, 1);
      end
      applyStimulus(0, 1, {ch1[m], ch0[m]}, 0, '0, 1);
    end
    applyStimulus(0, 0, '0, 0, '0, 1);
  endtask

  task automatic randomRun(input int cycles);
    for (int c = 0; c < cycles; c++)
      applyStimulus(0, $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 3) != 0,
                    4'($urandom), $urandom_range(0, 2) != 0);
  endtask

  initial begin
    logic [15:0] tmp;
    doReset();

    // Unconfigured engine must refuse input vectors.
    for (int c = 0; c < 20; c++) applyStimulus(0, 1, 2'b11, 1, 4'($urandom), 1);

    loadTables(16'h8001, 16'hFFFE, 0);

    // Back-to-back 0, 15, 5 with known truth table values.
    applyStimulus(0, 0, '0, 1, 4'd0, 1);
    checkOutput("dir_v0", {out_valid, dout}, 3'b101);
    applyStimulus(0, 0, '0, 1, 4'd15, 1);
    checkOutput("dir_v15", {out_valid, dout}, 3'b111);
    applyStimulus(0, 0, '0, 1, 4'd5, 1);
    checkOutput("dir_v5", {out_valid, dout}, 3'b110);
    applyStimulus(0, 0, '0, 0, '0, 1);

    // Backpressure: result pending with out_ready low, then release.
    applyStimulus(0, 0, '0, 1, 4'd3, 0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, '0, 1, 4'd15, 0);
    checkOutput("bp_hold", {out_valid, dout}, 3'b110);
    applyStimulus(0, 0, '0, 1, 4'd15, 1);
    checkOutput("bp_next", {out_valid, dout}, 3'b111);
    applyStimulus(0, 0, '0, 0, '0, 1);

    randomRun(300);

    // cfg_start with a pending result discards it; reload with ch0 all zero.
    applyStimulus(0, 0, '0, 1, 4'd15, 0);
    applyStimulus(1, 0, '0, 1, 4'd15, 0);
    checkOutput("start_discard", out_valid, 0);
    tmp = 16'($urandom);
    for (int m = 0; m < DEPTH; m++) applyStimulus(0, 1, {tmp[m], 1'b0}, 0, '0, 1);
    applyStimulus(0, 0, '0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1, 4'd0, 1);
    checkOutput("reload_v0", dout[0], 0);

    // Hit counter: 4 of 10 vectors select a set channel 0 bit.
    loadTables(16'h00F0, 16'($urandom), 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 1, 4'((i + 4) % 10), 1);
    applyStimulus(0, 0, '0, 0, '0, 1);
`ifdef KMAP_LUT_HITCNT_EN
    checkOutput("hits_ten", hit_count, 4);
    applyStimulus(1, 0, '0, 0, '0, 1);
    checkOutput("hits_clear", hit_count, 0);
    for (int m = 0; m < DEPTH; m++) applyStimulus(0, 1, 2'($urandom), 0, '0, 1);
`endif

    // Reset mid-load, then a full reload with random tables.
    applyStimulus(1, 0, '0, 0, '0, 1);
    for (int m = 0; m < 5; m++) applyStimulus(0, 1, 2'b11, 0, '0, 1);
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 2'b11, 1, 4'($urandom), 1);
    loadTables(16'($urandom), 16'($urandom), 1);
    randomRun(400);

    // Restart a load halfway through, then finish it and run again.
    applyStimulus(1, 0, '0, 0, '0, 1);
    for (int m = 0; m < 7; m++) applyStimulus(0, 1, 2'($urandom), 0, '0, 1);
    loadTables(16'($urandom), 16'($urandom), 1);
    randomRun(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
